// File: rtl/onchipalarm_botones_if.sv
// Avalon-MM slave bus bundle for the push-button input port.
// The master side drives the register select and write strobe, and the
// slave side returns read data and the level interrupt.
interface onchipalarm_botones_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/onchipalarm_botones.sv
// Push-button input port for the alarm-clock SoC.
// Each button is synchronized and debounced. Rising edges of the debounced
// level are latched in a write-1-to-clear capture register, and that register
// drives a maskable level interrupt. Reads are zero-wait-state.
// Register map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (w1c).
module onchipalarm_botones #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_port,
  onchipalarm_botones_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign rise  = deb & ~deb_q;
  assign clr   = (wr_en && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  // Two-flop synchronizer and per-bit debounce counters.
  // For a single bit, s2 moving while a count is in progress can only mean it
  // went back to deb, so the equality test alone restarts the count. Counting
  // starts on the first cycle s2 differs from deb, so a new level reaches deb
  // exactly DEBOUNCE_CYCLES edges after it appears at s2. The counter stops at
  // DEBOUNCE_CYCLES-1 and clears as deb takes the new level, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1    <= in_port;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mask register writes and edge capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && (bus.address == 2'd2)) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr) | rise;
    end
  end

  // Combinational read mux; unused upper bits always read as zero.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = deb;
      2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
      2'd3:    bus.readdata[WIDTH-1:0] = edge_cap;
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_cap & irq_mask);

endmodule
